mem_stage: RTL and testbench

Memory-access stage of the RISC-V pipeline, directly downstream of the execute stage. It takes the ALU result as the effective address and rs2 data as store data. It drives a request/ready data-memory port with byte enables, then sign- or zero-extends load data. It registers the result toward write-back and stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 258 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RISC-V pipeline.
// Takes the execute-stage result as the effective address and rs2 as store data.
// Drives a request/ready data-memory port, extends load data and registers the
// write-back fields. Upstream is stalled while an access is outstanding.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rd2,
  input  logic [2:0]  func3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_fault
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Byte enables for a byte/half/word access at byte offset off.
  function automatic logic [3:0] enc_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated across all lanes so the memory just applies be.
  function automatic logic [31:0] enc_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      2'b10:   w = d;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Right-justify the selected lane of the read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      2'b11:   b = rdata[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h00_0000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = rdata;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Unsupported width/sign encodings, read+write together, or misalignment.
  function automatic logic access_fault(input logic mr, input logic mw,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic f;
    if (mr && mw) begin
      f = 1'b1;
    end else if (mr) begin
      case (f3)
        3'b000, 3'b100: f = 1'b0;
        3'b001, 3'b101: f = off[0];
        3'b010:         f = (off != 2'b00);
        default:        f = 1'b1;
      endcase
    end else if (mw) begin
      case (f3)
        3'b000:  f = 1'b0;
        3'b001:  f = off[0];
        3'b010:  f = (off != 2'b00);
        default: f = 1'b1;
      endcase
    end else begin
      f = 1'b0;
    end
    return f;
  endfunction

  state_t      state_r;
  state_t      state_s;

  logic        is_mem_s;
  logic        fault_s;
  logic        stall_s;
  logic        start_s;
  logic        retire_s;
  logic [31:0] wb_data_s;
  logic [4:0]  wb_rd_s;
  logic        wb_reg_write_s;
  logic        wb_fault_s;

  logic        dmem_we_r;
  logic [31:0] dmem_addr_r;
  logic [3:0]  dmem_be_r;
  logic [31:0] dmem_wdata_r;
  logic [31:0] alu_r;
  logic [2:0]  f3_r;
  logic        is_load_r;
  logic [4:0]  rd_r;
  logic        reg_write_r;

  logic        wb_valid_r;
  logic [31:0] wb_data_r;
  logic [4:0]  wb_rd_r;
  logic        wb_reg_write_r;
  logic        wb_fault_r;

  assign is_mem_s = mem_read | mem_write;
  assign fault_s  = access_fault(mem_read, mem_write, func3, alu_result[1:0]);

  // Next-state, stall and write-back field selection.
  always_comb begin
    state_s        = state_r;
    stall_s        = 1'b0;
    start_s        = 1'b0;
    retire_s       = 1'b0;
    wb_data_s      = wb_data_r;
    wb_rd_s        = wb_rd_r;
    wb_reg_write_s = wb_reg_write_r;
    wb_fault_s     = wb_fault_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_in && !is_mem_s) begin
          retire_s       = 1'b1;
          wb_data_s      = alu_result;
          wb_rd_s        = rd_in;
          wb_reg_write_s = reg_write_in;
          wb_fault_s     = 1'b0;
        end else if (valid_in && fault_s) begin
          retire_s       = 1'b1;
          wb_data_s      = alu_result;
          wb_rd_s        = rd_in;
          wb_reg_write_s = 1'b0;
          wb_fault_s     = 1'b1;
        end else if (valid_in) begin
          start_s = 1'b1;
          stall_s = 1'b1;
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (dmem_ready) begin
          retire_s       = 1'b1;
          wb_data_s      = is_load_r ? load_extend(f3_r, alu_r[1:0], dmem_rdata) : alu_r;
          wb_rd_s        = rd_r;
          wb_reg_write_s = reg_write_r;
          wb_fault_s     = 1'b0;
          state_s        = ST_IDLE;
        end else begin
          stall_s = 1'b1;
          state_s = ST_ACCESS;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request fields are captured on IDLE->ACCESS and held stable until ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= 32'h0000_0000;
      dmem_be_r    <= 4'b0000;
      dmem_wdata_r <= 32'h0000_0000;
      alu_r        <= 32'h0000_0000;
      f3_r         <= 3'b000;
      is_load_r    <= 1'b0;
      rd_r         <= 5'd0;
      reg_write_r  <= 1'b0;
    end else if (start_s) begin
      dmem_we_r    <= mem_write;
      dmem_addr_r  <= {alu_result[31:2], 2'b00};
      dmem_be_r    <= enc_be(func3, alu_result[1:0]);
      dmem_wdata_r <= mem_write ? enc_wdata(func3, rd2) : 32'h0000_0000;
      alu_r        <= alu_result;
      f3_r         <= func3;
      is_load_r    <= mem_read;
      rd_r         <= rd_in;
      reg_write_r  <= reg_write_in;
    end
  end

  // Write-back register: one-cycle valid pulse, fields hold between retirements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_r     <= 1'b0;
      wb_data_r      <= 32'h0000_0000;
      wb_rd_r        <= 5'd0;
      wb_reg_write_r <= 1'b0;
      wb_fault_r     <= 1'b0;
    end else begin
      wb_valid_r     <= retire_s;
      wb_data_r      <= wb_data_s;
      wb_rd_r        <= wb_rd_s;
      wb_reg_write_r <= wb_reg_write_s;
      wb_fault_r     <= wb_fault_s;
    end
  end

  // Reset gating keeps stall low while the stage is held in reset.
  assign stall        = stall_s & rst_n;
  assign dmem_req     = (state_r == ST_ACCESS);
  assign dmem_we      = dmem_we_r;
  assign dmem_addr    = dmem_addr_r;
  assign dmem_be      = dmem_be_r;
  assign dmem_wdata   = dmem_wdata_r;
  assign wb_valid     = wb_valid_r;
  assign wb_data      = wb_data_r;
  assign wb_rd        = wb_rd_r;
  assign wb_reg_write = wb_reg_write_r;
  assign wb_fault     = wb_fault_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instructions, all checked against a byte-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] rd2 = 32'h0;
  logic [2:0]  func3 = 3'b000;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [4:0]  rd_in = 5'd0;
  logic        reg_write_in = 1'b0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_fault;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cycles;

  logic [31:0] exp_wb_data = 32'h0;
  logic [4:0]  exp_wb_rd = 5'd0;
  logic        exp_wb_rw = 1'b0;
  logic        exp_wb_fault = 1'b0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result(alu_result), .rd2(rd2),
    .func3(func3), .mem_read(mem_read), .mem_write(mem_write), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, alignment by modulo, lane
  // replication and shift/mask extension.
  function automatic void model(input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, output logic flt,
                                output logic [3:0] be, output logic [31:0] wdat,
                                output logic [31:0] ld);
    int nbytes;
    int off;
    logic [31:0] mask;
    logic [31:0] v;
    off = int'(addr % 4);
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    flt = 1'b0;
    if (mr && mw) flt = 1'b1;
    if (mr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) flt = 1'b1;
    if (mw && f3 > 3'd2) flt = 1'b1;
    if ((mr || mw) && (off % nbytes) != 0) flt = 1'b1;
    be = 4'(((1 << nbytes) - 1) << off);
    wdat = 32'h0;
    for (int i = 0; i < 4; i++) wdat[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    if (!mw) wdat = 32'h0;
    v = rdata >> (8 * off);
    if (nbytes < 4) begin
      mask = (32'd1 << (8 * nbytes)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*nbytes-1]) v = v | ~mask;
    end
    ld = v;
  endfunction

  // Present one instruction, serve the memory with `waits` wait cycles, check everything.
  task automatic do_op(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw, input int waits, input logic [31:0] rdata);
    logic flt;
    logic [3:0] be;
    logic [31:0] wdat;
    logic [31:0] ld;
    model(mr, mw, f3, addr, wd, rdata, flt, be, wdat, ld);
    valid_in = 1'b1; mem_read = mr; mem_write = mw; func3 = f3;
    alu_result = addr; rd2 = wd; rd_in = rd; reg_write_in = rw;
    #1;
    stall_cycles = 0;
    if (!(mr || mw) || flt) begin
      check("stall_nomem", {31'd0, stall}, 32'd0);
      check("req_nomem", {31'd0, dmem_req}, 32'd0);
      @(posedge clk); #1;
      valid_in = 1'b0;
      exp_wb_data = addr; exp_wb_rd = rd; exp_wb_rw = flt ? 1'b0 : rw; exp_wb_fault = flt;
      check("req_after_nomem", {31'd0, dmem_req}, 32'd0);
    end else begin
      check("stall_decode", {31'd0, stall}, 32'd1);
      stall_cycles = 1;
      @(posedge clk); #1;
      for (int w = 0; w <= waits; w++) begin
        dmem_ready = (w == waits);
        dmem_rdata = (w == waits) ? rdata : $urandom;
        alu_result = $urandom;
        rd2 = $urandom;
        #1;
        check("req", {31'd0, dmem_req}, 32'd1);
        check("we", {31'd0, dmem_we}, {31'd0, mw});
        check("addr", dmem_addr, {addr[31:2], 2'b00});
        check("be", {28'd0, dmem_be}, {28'd0, be});
        if (mw) check("wdata", dmem_wdata, wdat);
        check("wbv_access", {31'd0, wb_valid}, 32'd0);
        check("stall_access", {31'd0, stall}, {31'd0, (w != waits)});
        if (stall) stall_cycles++;
        @(posedge clk); #1;
      end
      dmem_ready = 1'b0;
      valid_in = 1'b0;
      exp_wb_data = mr ? ld : addr; exp_wb_rd = rd; exp_wb_rw = rw; exp_wb_fault = 1'b0;
      check("stall_cycles", stall_cycles, waits + 1);
      check("req_after", {31'd0, dmem_req}, 32'd0);
    end
    check("wb_valid", {31'd0, wb_valid}, 32'd1);
    check("wb_data", wb_data, exp_wb_data);
    check("wb_rd", {27'd0, wb_rd}, {27'd0, exp_wb_rd});
    check("wb_rw", {31'd0, wb_reg_write}, {31'd0, exp_wb_rw});
    check("wb_fault", {31'd0, wb_fault}, {31'd0, exp_wb_fault});
  endtask

  // One bubble cycle: wb_valid must drop and the fields must hold.
  task automatic idle_cycle();
    valid_in = 1'b0;
    @(posedge clk); #1;
    check("idle_wbv", {31'd0, wb_valid}, 32'd0);
    check("idle_data", wb_data, exp_wb_data);
    check("idle_rd", {27'd0, wb_rd}, {27'd0, exp_wb_rd});
    check("idle_fault", {31'd0, wb_fault}, {31'd0, exp_wb_fault});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
    check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    check({tag, "_addr"}, dmem_addr, 32'd0);
    check({tag, "_be"}, {28'd0, dmem_be}, 32'd0);
    check({tag, "_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_wbdata"}, wb_data, 32'd0);
    check({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
    check({tag, "_wbrw"}, {31'd0, wb_reg_write}, 32'd0);
    check({tag, "_wbfault"}, {31'd0, wb_fault}, 32'd0);
  endtask

  initial begin
    // Reset values
    #2;
    check_all_zero("reset");
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SB at 0x1003
    do_op(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hDEAD_BEA5, 5'd7, 1'b1, 0, 32'h0);
    check("sb_wbdata", wb_data, 32'h0000_1003);
    idle_cycle();

    // LB, LBU, LH at 0x2002
    do_op(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0, 5'd3, 1'b1, 0, 32'h12F0_8000);
    check("lb_value", wb_data, 32'hFFFF_FFF0);
    do_op(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 5'd4, 1'b1, 0, 32'h12F0_8000);
    check("lbu_value", wb_data, 32'h0000_00F0);
    do_op(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd5, 1'b1, 1, 32'h12F0_8000);
    check("lh_value", wb_data, 32'h0000_12F0);

    // LW with 2 wait cycles
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_2460, 32'h0, 5'd9, 1'b1, 2, 32'hCAFE_F00D);
    check("lw_value", wb_data, 32'hCAFE_F00D);
    check("lw_stall3", stall_cycles, 3);

    // Faults: misaligned LH, misaligned SW, bad load func3
    do_op(1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0, 5'd10, 1'b1, 0, 32'h0);
    check("lh_mis_fault", {31'd0, wb_fault}, 32'd1);
    do_op(1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'h1234_5678, 5'd11, 1'b1, 0, 32'h0);
    check("sw_mis_rw", {31'd0, wb_reg_write}, 32'd0);
    do_op(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 5'd12, 1'b1, 0, 32'h0);
    check("ld011_fault", {31'd0, wb_fault}, 32'd1);
    idle_cycle();

    // Mixed stream: ADD, SW, ADD back to back
    do_op(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd1, 1'b1, 0, 32'h0);
    check("mix_add1", wb_data, 32'h0000_0055);
    do_op(1'b0, 1'b1, 3'b010, 32'h0000_4440, 32'h0BAD_F00D, 5'd2, 1'b0, 0, 32'h0);
    check("mix_sw", wb_data, 32'h0000_4440);
    check("mix_hold1", stall_cycles, 1);
    do_op(1'b0, 1'b0, 3'b000, 32'h0000_0066, 32'h0, 5'd3, 1'b1, 0, 32'h0);
    check("mix_add2", wb_data, 32'h0000_0066);

    // Reset during ACCESS
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010;
    alu_result = 32'h0000_5000; rd_in = 5'd20; reg_write_in = 1'b1;
    #1;
    check("rst_decode_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      dmem_ready = 1'b0;
      #1;
      check("rst_wait_req", {31'd0, dmem_req}, 32'd1);
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_wb_data = 32'h0; exp_wb_rd = 5'd0; exp_wb_rw = 1'b0; exp_wb_fault = 1'b0;
    idle_cycle();
    check("rst_after_req", {31'd0, dmem_req}, 32'd0);
    idle_cycle();
    do_op(1'b1, 1'b0, 3'b101, 32'h0000_6002, 32'h0, 5'd21, 1'b1, 1, 32'h8001_7FFF);
    check("post_rst_lhu", wb_data, 32'h0000_8001);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic mr;
      logic mw;
      int kind;
      kind = int'($urandom_range(0, 9));
      mr = (kind < 4) || (kind == 9);
      mw = (kind >= 4 && kind < 8) || (kind == 9);
      if ($urandom_range(0, 5) == 0) begin
        idle_cycle();
      end else begin
        idle_cycle_skip: begin end
      end
      do_op(mr, mw, 3'($urandom_range(0, 7) & ($urandom_range(0, 3) == 0 ? 7 : 5)),
            $urandom, $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
